// File: rtl/dither_pkg.sv
// Shared types, reset patterns and modulo-7 helper for the 7-phase temporal dither controller.
package dither_pkg;

  localparam int PHASES = 7;

  typedef logic [6:0] pat_t;
  typedef logic [2:0] ph_t;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_ACK,
    CFG_WAIT
  } cfg_st_t;

  // Level k pattern; bit 6 is emitted at phase 0 with zero rotation.
  localparam pat_t RST_PAT [1:6] = '{
    7'b0001000,
    7'b0100010,
    7'b1010100,
    7'b1010101,
    7'b1101011,
    7'b1110111
  };

  // Both operands are expected in 0..6.
  function automatic ph_t add_mod7(input ph_t a, input ph_t b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd7) s = s - 4'd7;
    return s[2:0];
  endfunction

endpackage

// File: rtl/mod7_acc.sv
// Modulo-7 offset accumulator: adds step on add, clear has priority; 1-cycle update latency.
module mod7_acc
  import dither_pkg::*;
(
  input  logic clk7x,
  input  logic rst,
  input  logic clr,
  input  logic add,
  input  ph_t  step,
  output ph_t  acc
);

  always_ff @(posedge clk7x) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= add_mod7(acc, step);
    end
  end

endmodule

// File: rtl/dither_phase_ctrl.sv
// 7-phase dither sequencer with shadowed pattern table committed on vsync; outputs registered (1 cycle).
// Line/frame rotation is built only when DITHER_FRC_ROT_EN is defined.
module dither_phase_ctrl
  import dither_pkg::*;
#(
  parameter int LINE_ROT  = 1,
  parameter int FRAME_ROT = 3
) (
  input  logic       rst,
  input  logic       clk7x,
  input  logic       pix_stb,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       en,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [6:0] cfg_wdata,
  output logic       cfg_ack,
  output logic       cfg_err,
  output logic       cfg_pend,
  output logic [5:0] lvl_mask,
  output logic [2:0] phase_o,
  output logic       locked
);

  localparam ph_t LINE_STEP  = ph_t'(LINE_ROT);
  localparam ph_t FRAME_STEP = ph_t'(FRAME_ROT);
  localparam ph_t LAST_PHASE = ph_t'(PHASES - 1);

  logic vs_q;
  logic vs_rise;
  ph_t  rot;

  always_ff @(posedge clk7x) begin
    if (rst) vs_q <= 1'b0;
    else     vs_q <= vsync_i;
  end

  assign vs_rise = vsync_i & ~vs_q;

`ifdef DITHER_FRC_ROT_EN
  logic hs_q;
  logic hs_rise;
  ph_t  line_off;
  ph_t  frame_off;

  always_ff @(posedge clk7x) begin
    if (rst) hs_q <= 1'b0;
    else     hs_q <= hsync_i;
  end

  assign hs_rise = hsync_i & ~hs_q;

  // A frame edge restarts the line offset, overriding any same-cycle line edge.
  mod7_acc u_line_acc (
    .clk7x (clk7x),
    .rst   (rst),
    .clr   (vs_rise),
    .add   (hs_rise),
    .step  (LINE_STEP),
    .acc   (line_off)
  );

  mod7_acc u_frame_acc (
    .clk7x (clk7x),
    .rst   (rst),
    .clr   (1'b0),
    .add   (vs_rise),
    .step  (FRAME_STEP),
    .acc   (frame_off)
  );

  assign rot = add_mod7(line_off, frame_off);
`else
  logic unused_rot_cfg;

  assign rot            = '0;
  assign unused_rot_cfg = ^{hsync_i, LINE_STEP, FRAME_STEP};
`endif

  // Phase counter; a strobe always marks phase 0, whatever the counter held.
  ph_t phase;
  ph_t phase_eff;
  ph_t idx;

  always_ff @(posedge clk7x) begin
    if (rst) begin
      phase  <= '0;
      locked <= 1'b0;
    end else if (pix_stb) begin
      phase  <= 3'd1;
      locked <= (phase == '0);
    end else begin
      if (phase == '0) locked <= 1'b0;
      phase <= (phase == LAST_PHASE) ? '0 : phase + 3'd1;
    end
  end

  assign phase_eff = pix_stb ? '0 : phase;
  assign idx       = add_mod7(phase_eff, rot);

  pat_t active [1:6];
  pat_t shadow [1:6];
  logic [5:0] mask_nxt;

  always_comb begin
    mask_nxt = '0;
    for (int k = 1; k <= 6; k++) begin
      mask_nxt[k-1] = en & active[k][3'd6 - idx];
    end
  end

  always_ff @(posedge clk7x) begin
    if (rst) begin
      lvl_mask <= '0;
      phase_o  <= '0;
    end else begin
      lvl_mask <= mask_nxt;
      phase_o  <= phase_eff;
    end
  end

  cfg_st_t cfg_st;
  cfg_st_t cfg_st_nxt;
  logic    accept;
  logic    addr_ok;

  always_ff @(posedge clk7x) begin
    if (rst) cfg_st <= CFG_IDLE;
    else     cfg_st <= cfg_st_nxt;
  end

  // After an ack, the requester must drop cfg_we before a new write is taken.
  always_comb begin
    cfg_st_nxt = cfg_st;
    accept     = 1'b0;
    case (cfg_st)
      CFG_IDLE: begin
        if (cfg_we) begin
          accept     = 1'b1;
          cfg_st_nxt = CFG_ACK;
        end
      end
      CFG_ACK:  cfg_st_nxt = cfg_we ? CFG_WAIT : CFG_IDLE;
      CFG_WAIT: if (!cfg_we) cfg_st_nxt = CFG_IDLE;
      default:  cfg_st_nxt = CFG_IDLE;
    endcase
  end

  assign cfg_ack = (cfg_st == CFG_ACK);
  assign addr_ok = (cfg_addr != 3'd0) && (cfg_addr != 3'd7);

  // Commit copies the pre-write shadow; a same-cycle write lands afterwards and stays pending.
  always_ff @(posedge clk7x) begin
    if (rst) begin
      active   <= RST_PAT;
      shadow   <= RST_PAT;
      cfg_pend <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (vs_rise) begin
        active   <= shadow;
        cfg_pend <= 1'b0;
      end
      if (accept) begin
        if (addr_ok) begin
          shadow[cfg_addr] <= cfg_wdata;
          cfg_pend         <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule
